// File: rtl/alu_pkg.sv
// Shared constants for the registered two-function ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 2;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_AND = 1'b1;

endpackage : alu_pkg

// File: rtl/alu_2bit_comb.sv
// Combinational function table of the ALU: modular add or bitwise AND.
module alu_2bit_comb #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             sel,
  output logic [WIDTH-1:0] result
);
  import alu_pkg::*;

  // Select the operation; the add carry-out falls off the top bit.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (sel)
      SEL_ADD: result = ain + bin;
      SEL_AND: result = ain & bin;
      default: result = {WIDTH{1'b0}};
    endcase
  end

endmodule : alu_2bit_comb

// File: rtl/alu_2bit.sv
// Registered two-function ALU: combinational core plus a resettable result register.
module alu_2bit #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             sel,
  output logic [WIDTH-1:0] zout
);

  logic [WIDTH-1:0] zout_d;
  logic [WIDTH-1:0] zout_q;

  alu_2bit_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .ain    (ain),
    .bin    (bin),
    .sel    (sel),
    .result (zout_d)
  );

  // Result register; reset wins over the operation launched in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      zout_q <= {WIDTH{1'b0}};
    end else begin
      zout_q <= zout_d;
    end
  end

  assign zout = zout_q;

endmodule : alu_2bit

// File: tb/tb_alu_2bit.sv
// Self-checking bench for alu_2bit: directed plan vectors plus randomized traffic vs an arithmetic model.
module tb_alu_2bit;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] ain = '0;
  logic [W-1:0] bin = '0;
  logic         sel = 1'b0;
  logic [W-1:0] zout;

  int checks = 0;
  int errors = 0;

  alu_2bit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ain  (ain),
    .bin  (bin),
    .sel  (sel),
    .zout (zout)
  );

  always #5 clk = ~clk;

  // Reference: reset clears, sel=0 is an unsigned sum modulo 2^W, sel=1 is bitwise AND.
  function automatic int model(int a, int b, int s, int r);
    int m = 1 << W;
    int acc = 0;
    if (r != 0) return 0;
    if (s == 0) return (a + b) % m;
    for (int i = 0; i < W; i++)
      if (((a >> i) & 1) == 1 && ((b >> i) & 1) == 1) acc += (1 << i);
    return acc;
  endfunction

  // Apply one operation, clock it in, then check zout one edge later.
  task automatic step(input string tag, input int a, input int b, input int s, input int r);
    int exp;
    ain = a[W-1:0];
    bin = b[W-1:0];
    sel = s[0];
    rst = r[0];
    exp = model(a, b, s, r);
    @(posedge clk);
    #1;
    checks++;
    assert (zout === exp[W-1:0]) else begin
      errors++;
      $error("FAIL %s: a=%0d b=%0d sel=%0d rst=%0d zout=%0d expected=%0d",
             tag, a, b, s, r, zout, exp);
    end
  endtask

  initial begin
    // Reset with a live AND operation present, then release.
    step("reset", 3, 3, 1, 1);
    step("post_reset", 3, 3, 1, 0);

    step("and_3_2", 3, 2, 1, 0);
    step("and_0_3", 0, 3, 1, 0);
    step("and_3_3", 3, 3, 1, 0);
    step("and_3_1", 3, 1, 1, 0);

    step("add_0_0", 0, 0, 0, 0);
    step("add_0_2", 0, 2, 0, 0);
    step("add_1_1", 1, 1, 0, 0);

    step("wrap_3_1", 3, 1, 0, 0);
    step("wrap_1_3", 1, 3, 0, 0);
    step("wrap_3_2", 3, 2, 0, 0);
    step("wrap_3_3", 3, 3, 0, 0);

    for (int i = 0; i < 4; i++) step("sel_toggle", 3, 2, i % 2, 0);

    for (int i = 0; i < 3; i++) step("pre_midreset", 3, 3, 0, 0);
    step("midreset", 3, 3, 0, 1);
    step("after_midreset", 3, 3, 0, 0);

    for (int i = 0; i < 300; i++) begin
      step("random", int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
           int'($urandom_range(1, 0)), ($urandom_range(15, 0) == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_2bit

// File: doc/alu_2bit.md
Name: alu_2bit

Overview:
- Small registered two-function ALU: selects between modular addition and bitwise AND of two operands.
- Result is captured in an output register on each clock edge.
- Leaf datapath block used as a test/characterisation vehicle and as a building block in larger datapaths.

Parameters:
- WIDTH, 2, operand and result width in bits. All test vectors below use WIDTH=2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- ain  input  WIDTH  operand A, unsigned
- bin  input  WIDTH  operand B, unsigned
- sel  input  1  function select: 0 = ADD, 1 = AND
- zout  output  WIDTH  registered result

Behaviour:
- Reset is synchronous and active-high.
  - On a rising clk edge with rst=1, zout is set to 0.
  - rst has priority over any computation in the same cycle.
- Function table, computed combinationally from the current ain, bin and sel:
  - sel=0: next = (ain + bin) mod 2^WIDTH. Carry out is discarded; there is no carry or overflow port.
  - sel=1: next = ain & bin, bitwise.
- Register: on each rising clk edge with rst=0, zout <= next.
- Latency: exactly 1 cycle from inputs to zout.
- No handshake; a new operation is accepted every cycle.
- No state machine; the only state is the zout register.
- Wrap-around: any sum >= 2^WIDTH wraps. For WIDTH=2: 3+1 gives 0, 3+2 gives 1, 3+3 gives 2.
- Operands are unsigned; no sign extension anywhere.
- sel X/Z: output is don't-care. The bench must not drive X on sel or on the operands outside reset.
- Reset mid-operation: the operation launched in the reset cycle is lost, and zout reads 0 on the following cycle.
- After rst deasserts, the first valid result appears one edge later.
- Value on zout before the first reset is undefined. The bench must assert rst for at least one edge before checking.

Decomposition:
- Shared package (alu_pkg) holds:
  - select encodings: SEL_ADD = 1'b0, SEL_AND = 1'b1
  - default width constant: ALU_WIDTH = 2
- One combinational sub-module, alu_2bit_comb.
  - Ports: ain, bin, sel, result.
  - Implements the function table only.
  - Allows the combinational function to be checked without a clock.
- Top level instantiates alu_2bit_comb plus the reset-able output register.

Test Plan:
- Reset: drive rst=1 for one edge with ain=3, bin=3, sel=1 -> zout=0. Then rst=0 and one more edge -> zout=3.
- AND vectors (sel=1), one per cycle, each checked one cycle later:
  - ain=3, bin=2 -> 2
  - ain=0, bin=3 -> 0
  - ain=3, bin=3 -> 3
  - ain=3, bin=1 -> 1
- ADD without wrap (sel=0):
  - ain=0, bin=0 -> 0
  - ain=0, bin=2 -> 2
  - ain=1, bin=1 -> 2
- ADD with wrap (sel=0):
  - ain=3, bin=1 -> 0
  - ain=1, bin=3 -> 0
  - ain=3, bin=2 -> 1
  - ain=3, bin=3 -> 2
- Back-to-back select switching: alternate sel 0/1 every cycle with ain=3, bin=2 -> zout sequence 1, 2, 1, 2, lagging the inputs by one cycle.
- Mid-stream reset: run ADD ain=3, bin=3 for several cycles (zout=2), assert rst for one edge -> zout=0. Deassert -> zout=2 again one edge later.
